// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the burst memory model:
//   - access_size codes selecting the burst length
//   - burst_len(): access_size code -> number of 32-bit words in the burst
//   - state_t: control FSM states
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam logic [1:0] SZ_1W  = 2'b00;
  localparam logic [1:0] SZ_4W  = 2'b01;
  localparam logic [1:0] SZ_8W  = 2'b10;
  localparam logic [1:0] SZ_16W = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  // Number of words moved by a burst of the given access_size code.
  function automatic logic [4:0] burst_len(input logic [1:0] code);
    logic [4:0] len;
    case (code)
      SZ_1W:   len = 5'd1;
      SZ_4W:   len = 5'd4;
      SZ_8W:   len = 5'd8;
      SZ_16W:  len = 5'd16;
      default: len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// ---------------------------------------------------------------------------
// mem_byte_array
// Byte-wide storage with one 32-bit big-endian read port (combinational)
// and one 32-bit big-endian write port (rising edge). No reset: contents
// survive a control reset.
// Ports:
//   clock      in   write clock
//   i_we       in   write enable for the word at i_wr_addr
//   i_wr_addr  in   byte offset of the word to write
//   i_wr_data  in   word to write, MSB byte lands at the lowest offset
//   i_rd_addr  in   byte offset of the word to read
//   o_rd_data  out  word read, MSB byte from the lowest offset
// Byte offsets +1..+3 wrap modulo 2**AW; the controller only issues
// in-range word accesses.
// ---------------------------------------------------------------------------
module mem_byte_array #(
  parameter int DEPTH = 1048576,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);

  logic [7:0] r_mem [DEPTH];

  logic [AW-1:0] w_rd_a1, w_rd_a2, w_rd_a3;
  logic [AW-1:0] w_wr_a1, w_wr_a2, w_wr_a3;

  assign w_rd_a1 = i_rd_addr + AW'(1);
  assign w_rd_a2 = i_rd_addr + AW'(2);
  assign w_rd_a3 = i_rd_addr + AW'(3);
  assign w_wr_a1 = i_wr_addr + AW'(1);
  assign w_wr_a2 = i_wr_addr + AW'(2);
  assign w_wr_a3 = i_wr_addr + AW'(3);

  assign o_rd_data = {r_mem[i_rd_addr], r_mem[w_rd_a1], r_mem[w_rd_a2], r_mem[w_rd_a3]};

  // Big-endian word write: d[31:24] at the base offset.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data[31:24];
      r_mem[w_wr_a1]   <= i_wr_data[23:16];
      r_mem[w_wr_a2]   <= i_wr_data[15:8];
      r_mem[w_wr_a3]   <= i_wr_data[7:0];
    end
  end

endmodule

// File: rtl/burst_memory.sv
// ---------------------------------------------------------------------------
// burst_memory
// Byte-addressed big-endian unified memory with 1/4/8/16-word bursts,
// range/alignment checking and a writeback bypass on write data.
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-high reset of the control state
//   address       in   byte address of beat 0, sampled at the request edge
//   data_in       in   write data for the current beat
//   wm_bypass     in   alternate write data from writeback
//   do_wm_bypass  in   per beat, selects wm_bypass over data_in
//   access_size   in   burst length code (00=1, 01=4, 10=8, 11=16 words)
//   rw            in   1 = read, 0 = write
//   enable        in   request strobe (ignored while busy)
//   busy          out  burst in progress
//   data_out      out  registered read beat
//   data_valid    out  data_out holds a read beat this cycle
//   error         out  one-cycle pulse for a rejected request
// ---------------------------------------------------------------------------
module burst_memory
  import mem_pkg::*;
#(
  parameter int                MEM_DEPTH = 1048576,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h80020000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  input  logic [31:0]       wm_bypass,
  input  logic              do_wm_bypass,
  input  logic [1:0]        access_size,
  input  logic              rw,
  input  logic              enable,
  output logic              busy,
  output logic [31:0]       data_out,
  output logic              data_valid,
  output logic              error
);

  localparam int              AW       = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] LP_BASE  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t             r_state;
  logic [3:0]         r_beat;
  logic [3:0]         r_last;
  logic [ADDR_W-1:0]  r_offset;
  logic               r_busy;
  logic               r_data_valid;
  logic               r_error;
  logic [31:0]        r_data_out;

  logic [4:0]         w_len;
  logic [ADDR_W:0]    w_req_off;
  logic [ADDR_W:0]    w_req_end;
  logic               w_legal;
  logic [ADDR_W-1:0]  w_burst_off;
  logic [ADDR_W-1:0]  w_acc_off;
  logic               w_acc_in_range;
  logic               w_we;
  logic [31:0]        w_wr_data;
  logic [31:0]        w_rd_data;

  // Range check is carried out one bit wider than the address so that
  // neither the subtraction nor the end-of-burst sum can wrap.
  assign w_len     = burst_len(access_size);
  assign w_req_off = {1'b0, address} - LP_BASE;
  assign w_req_end = w_req_off + (ADDR_W+1)'({w_len, 2'b00});
  assign w_legal   = (address[1:0] == 2'b00) &&
                     ({1'b0, address} >= LP_BASE) &&
                     (w_req_end <= LP_DEPTH);

  assign w_burst_off = r_offset + ADDR_W'({r_beat, 2'b00});
  assign w_wr_data   = do_wm_bypass ? wm_bypass : data_in;

  // Word offset of this cycle's access: request offset in IDLE, else the burst beat.
  always_comb begin
    w_acc_off = w_burst_off;
    if (r_state == IDLE) begin
      w_acc_off = w_req_off[ADDR_W-1:0];
    end else begin
      w_acc_off = w_burst_off;
    end
  end

  // Defensive guard: never let a write land outside the storage.
  assign w_acc_in_range = (((ADDR_W+1)'(w_acc_off)) + (ADDR_W+1)'(4)) <= LP_DEPTH;

  // Write strobe for this edge; held off while reset is asserted.
  always_comb begin
    w_we = 1'b0;
    case (r_state)
      IDLE:     w_we = enable && w_legal && !rw;
      WR_BURST: w_we = 1'b1;
      RD_BURST: w_we = 1'b0;
      default:  w_we = 1'b0;
    endcase
    if (reset || !w_acc_in_range) begin
      w_we = 1'b0;
    end else begin
      w_we = w_we;
    end
  end

  mem_byte_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_array (
    .clock     (clock),
    .i_we      (w_we),
    .i_wr_addr (w_acc_off[AW-1:0]),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_acc_off[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // Control FSM: request acceptance, beat sequencing and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_beat       <= 4'd0;
      r_last       <= 4'd0;
      r_offset     <= '0;
      r_busy       <= 1'b0;
      r_data_valid <= 1'b0;
      r_error      <= 1'b0;
      r_data_out   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_error      <= 1'b0;
          r_data_valid <= 1'b0;
          if (enable) begin
            if (w_legal) begin
              r_offset <= w_req_off[ADDR_W-1:0];
              r_last   <= 4'(w_len - 5'd1);
              r_beat   <= 4'd1;
              if (rw) begin
                // Beat 0 is taken here, so the stream has one-cycle latency.
                r_data_out   <= w_rd_data;
                r_data_valid <= 1'b1;
              end
              if (w_len != 5'd1) begin
                r_state <= rw ? RD_BURST : WR_BURST;
                r_busy  <= 1'b1;
              end
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        RD_BURST: begin
          r_error      <= 1'b0;
          r_data_out   <= w_rd_data;
          r_data_valid <= 1'b1;
          r_beat       <= r_beat + 4'd1;
          if (r_beat == r_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_beat  <= 4'd0;
          end
        end
        WR_BURST: begin
          r_error      <= 1'b0;
          r_data_valid <= 1'b0;
          r_beat       <= r_beat + 4'd1;
          if (r_beat == r_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_beat  <= 4'd0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_data_valid <= 1'b0;
          r_error      <= 1'b0;
          r_beat       <= 4'd0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign error      = r_error;

endmodule
